// File: rtl/b12_resp_monitor.sv
// rtl/b12_resp_monitor.sv - b12 output observer emitting timestamped event records through a small FIFO
// Optional build macro B12_MON_OBS_GATE_EN adds the __obs detection gate input.
module b12_resp_monitor #(
    parameter int DEPTH       = 8,
    parameter int SILENCE_CYC = 32,
    parameter int OVF_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             nloss,
    input  logic [3:0]       nl,
    input  logic             speaker,
`ifdef B12_MON_OBS_GATE_EN
    input  logic             __obs,
`endif
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [15:0]      evt_data,
    output logic [7:0]       loss_cnt,
    output logic [5:0]       tone_period,
    output logic [OVF_W-1:0] overflow_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] SIL = 8'(SILENCE_CYC);

    // Event slot indices double as arbitration priority (lowest index wins).
    localparam int E_LOSS  = 0;
    localparam int E_NL    = 1;
    localparam int E_STOP  = 2;
    localparam int E_START = 3;

    function automatic logic [1:0] evt_type(input int idx);
        case (idx)
            E_LOSS:  return 2'b01;
            E_NL:    return 2'b00;
            E_STOP:  return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    typedef enum logic [1:0] {
        SILENT  = 2'd0,
        MEASURE = 2'd1,
        TONE    = 2'd2
    } tone_state_e;

    logic [3:0]       s_nl_q, p_nl_q;
    logic             s_nloss_q, p_nloss_q;
    logic             s_spk_q, p_spk_q;
    logic [7:0]       stamp_q;
    logic             obs_w;

    tone_state_e      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic [5:0]       period_q, period_d, period_new;
    logic             toggle, tone_start, tone_stop;

    logic [3:0]       det, set_w, eff_pend, win, pend_q, pend_d;
    logic [5:0]       det_pay [4];
    logic [5:0]       eff_pay [4];
    logic [5:0]       pay_q   [4];
    logic [7:0]       eff_stp [4];
    logic [7:0]       stp_q   [4];
    logic [15:0]      rec;
    logic             any_pend, pop, full, do_push, do_drop;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             evt_valid_q;
    logic [7:0]       loss_q, loss_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    // Input shadow registers and free-running stamp.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_nl_q    <= '0;
            p_nl_q    <= '0;
            s_nloss_q <= 1'b0;
            p_nloss_q <= 1'b0;
            s_spk_q   <= 1'b0;
            p_spk_q   <= 1'b0;
            stamp_q   <= '0;
        end else begin
            s_nl_q    <= nl;
            p_nl_q    <= s_nl_q;
            s_nloss_q <= nloss;
            p_nloss_q <= s_nloss_q;
            s_spk_q   <= speaker;
            p_spk_q   <= s_spk_q;
            stamp_q   <= stamp_q + 8'd1;
        end
    end

`ifdef B12_MON_OBS_GATE_EN
    logic s_obs_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) s_obs_q <= 1'b0;
        else       s_obs_q <= __obs;
    end
    assign obs_w = s_obs_q;
`else
    assign obs_w = 1'b1;
`endif

    assign toggle     = s_spk_q ^ p_spk_q;
    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign period_new = (cnt_q >= 8'd62) ? 6'd63 : 6'(cnt_q + 8'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= SILENT;
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SILENT:  if (toggle) state_d = MEASURE;
            MEASURE: begin
                if (toggle)              state_d = TONE;
                else if (cnt_inc >= SIL) state_d = SILENT;
            end
            TONE:    if (!toggle && cnt_inc >= SIL) state_d = SILENT;
            default: state_d = SILENT;
        endcase
    end

    // cnt measures cycles since the last toggle in every state.
    always_comb begin
        cnt_d      = toggle ? 8'd0 : cnt_inc;
        period_d   = period_q;
        tone_start = 1'b0;
        tone_stop  = 1'b0;
        case (state_q)
            MEASURE: if (toggle) begin
                tone_start = 1'b1;
                period_d   = period_new;
            end
            TONE:    if (!toggle && cnt_inc >= SIL) tone_stop = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        det          = '0;
        det[E_LOSS]  = s_nloss_q & ~p_nloss_q;
        det[E_NL]    = (s_nl_q != p_nl_q);
        det[E_STOP]  = tone_stop;
        det[E_START] = tone_start;
        det_pay[E_LOSS]  = {2'b00, s_nl_q};
        det_pay[E_NL]    = {2'b00, s_nl_q};
        det_pay[E_STOP]  = 6'd0;
        det_pay[E_START] = period_d;
        set_w = det & {4{obs_w}};
    end

    // New detections merge over already-pending slots and may win this cycle.
    always_comb begin
        rec = '0;
        for (int i = 0; i < 4; i++) begin
            eff_pend[i] = pend_q[i] | set_w[i];
            eff_pay[i]  = set_w[i] ? det_pay[i] : pay_q[i];
            eff_stp[i]  = set_w[i] ? stamp_q    : stp_q[i];
        end
        win = eff_pend & (~eff_pend + 4'd1);
        for (int i = 0; i < 4; i++) begin
            if (win[i]) rec = {evt_type(i), eff_pay[i], eff_stp[i]};
        end
        any_pend = |eff_pend;
        pop      = evt_valid_q & evt_ready;
        full     = (count_q == CNT_W'(DEPTH));
        do_push  = any_pend & (~full | pop);
        do_drop  = any_pend & full & ~pop;
        pend_d   = eff_pend & ~win;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
        loss_d   = (det[E_LOSS] && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
        ovf_d    = (do_drop && ovf_q != {OVF_W{1'b1}}) ? ovf_q + OVF_W'(1) : ovf_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            loss_q      <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                pay_q[i] <= '0;
                stp_q[i] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            evt_valid_q <= (count_d != '0);
            loss_q      <= loss_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                pay_q[i] <= eff_pay[i];
                stp_q[i] <= eff_stp[i];
            end
        end
    end

    // When full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= rec;
    end

    assign evt_valid    = evt_valid_q;
    assign evt_data     = evt_valid_q ? mem[rd_ptr_q] : 16'd0;
    assign loss_cnt     = loss_q;
    assign tone_period  = period_q;
    assign overflow_cnt = ovf_q;

endmodule
